m3_dequant_engine: RTL and testbench
====================================

# m3_dequant_engine

Parametrised dequantisation and zig-zag reorder engine for the image decompressor's Milestone 3 path.
- Reads a run of 8x8 coefficient blocks from external SRAM. Each block is 64 signed 16-bit words stored in zig-zag order.
- Scales each coefficient by a power-of-two quantisation step selected by mode.
- Writes the results back to SRAM in raster order, ready for the IDCT stage.
- Sits between the top-level milestone sequencer and the SRAM controller, using the codebase's milestone_start/milestone_done handshake.

## Interface
Parameters:
- NUM_BLOCKS, 1200: blocks processed per run (≥1).
- SRC_BASE, 18'd76800: SRAM word address of zig-zag coefficient 0 of block 0.
- DST_BASE, 18'd153600: SRAM word address of raster coefficient 0 of block 0.
- GROUP, 8: coefficients per read/write burst. Legal values: 1, 2, 4, 8, 16.

Ports:
- Clock_50  in  1  system clock. One clock domain.
- Resetn  in  1  reset; synchronous, active-low.
- milestone_start  in  1  level request to run.
- q_sel  in  1  quantisation matrix select (0=Q0, 1=Q1). Sampled when start is accepted.
- milestone_done  out  1  run complete; held until start drops.
- busy  out  1  high from start acceptance until DONE state exits.
- SRAM_read_data  in  16  read data, valid 2 cycles after its address.
- SRAM_address  out  18  registered word address.
- SRAM_write_data  out  16  registered write data.
- SRAM_we_n  out  1  registered write enable, active low.

## Operation
- States: IDLE, READ, DRAIN, WRITE, DONE.
- **IDLE**
  - If milestone_start=1 and milestone_done=0: latch q_sel, clear blk/zz counters, go to READ.
  - On that same edge, SRAM_address<=SRC_BASE and busy<=1.
  - If milestone_done=1 and milestone_start=0: clear milestone_done.
- **READ** (GROUP cycles): SRAM_address = SRC_BASE + blk*64 + zz, with zz incrementing each cycle. SRAM_we_n=1.
- **DRAIN** (2 cycles): address held, no new reads.
- **Read capture**: the word for the address driven in cycle t is captured into buf[k] at the end of cycle t+2.
- **WRITE** (GROUP cycles)
  - Each cycle drives: SRAM_address = DST_BASE + blk*64 + ZZ2R[zz_k], SRAM_write_data = deq(buf[k]), SRAM_we_n=0.
  - After the last beat: if zz reached 64, then blk++ and zz=0.
  - Then go to READ, or to DONE if blk = NUM_BLOCKS.
- **DONE** (1 cycle): SRAM_we_n<=1, milestone_done<=1, busy<=0, go to IDLE.
- **ZZ2R**: standard JPEG zig-zag-to-raster table (64 entries). Examples: 0→0, 1→1, 2→8, 3→16, 63→63.
- **deq(c)** = c <<< s, where s depends on d = row+col of the raster position:
  - Q0: d=0→3, d=1→2, d=2..3→3, d=4..5→4, d=6..7→5, d≥8→6.
  - Q1: d=0→3, d=1..3→1, d=4..5→2, d=6..7→3, d=8..9→4, d≥10→5.
- **Arithmetic**
  - Shift is computed in 23-bit signed.
  - Result reduced to 16 bits per the Configuration section.
  - Address sums are modulo 2^18 (wrap silently).

## Timing
- **Reset values**: milestone_done=0, busy=0, SRAM_address=0, SRAM_write_data=0, SRAM_we_n=1, state IDLE.
- **Reset mid-run**: Resetn=0 sampled at any edge forces all reset values at that edge. Any partial write burst is abandoned; SRAM_we_n is 1 from the next cycle.
- **Per-group latency**: 2*GROUP+2 cycles.
- **Run length**: busy is high for NUM_BLOCKS*(64/GROUP)*(2*GROUP+2)+1 cycles. For GROUP=8 that is 145 cycles per block.
- **Done timing**: milestone_done rises at the DONE→IDLE edge. It falls one cycle after milestone_start is sampled 0.
- **Start while done=1** is ignored; no second run begins until done has cleared.
- **q_sel changes mid-run** have no effect.
- **Bus ownership**: SRAM_we_n=0 only in WRITE. There is never a read and a write in the same cycle.

## Configuration
- **M3_SATURATE_EN defined**: deq result clamps to [-32768, 32767].
- **Undefined**: deq result is the low 16 bits of the shifted value (two's-complement wrap).

## Test plan
- **Q0 basics**: NUM_BLOCKS=1, GROUP=8, q_sel=0, src zz0=5 and zz1=-3.
  - Expect DST+0=40 and DST+1=16'hFFF4.
  - Expect exactly 64 write cycles and busy high for 145 cycles.
- **Q1 and reorder**: same block with q_sel=1 → DST+0=40, DST+1=16'hFFFA. Also src zz2=7 → DST+8=14 (Q1, d=1).
- **Overflow**: zz63=1000, q_sel=0.
  - With M3_SATURATE_EN: DST+63=16'h7FFF.
  - Without: DST+63=16'hFA00.
  - Also zz63=-1000 with macro → 16'h8000.
- **Multi-block and GROUP sweep**: NUM_BLOCKS=3, GROUP∈{1,4,16}.
  - Each src word = its zz index. Every dst word matches the model.
  - Busy cycles = 3*(64/GROUP)*(2*GROUP+2)+1.
  - No read and write ever occur in the same cycle.
- **Handshake**: hold start=1 after done → no restart. Drop start → done falls 1 cycle later. Reassert start → second run matches the first.
- **Reset mid-run**: assert Resetn=0 during a WRITE beat.
  - All outputs take reset values at that edge and SRAM_we_n stays 1.
  - A subsequent start completes a full correct run.

Source files
------------

// File: rtl/m3_dequant_engine.sv
// m3_dequant_engine: reads zig-zag ordered 8x8 coefficient blocks from SRAM, scales each
// coefficient by a power-of-two step, and writes the results back in raster order.
// Work is done in groups: GROUP reads, 2 drain cycles, then GROUP writes.
// Optional macro M3_SATURATE_EN: clamp results to 16-bit signed range instead of wrapping.
module m3_dequant_engine #(
    parameter int unsigned NUM_BLOCKS = 1200,
    parameter logic [17:0] SRC_BASE   = 18'd76800,
    parameter logic [17:0] DST_BASE   = 18'd153600,
    parameter int unsigned GROUP      = 8
) (
    input  logic        Clock_50,
    input  logic        Resetn,
    input  logic        milestone_start,
    input  logic        q_sel,
    output logic        milestone_done,
    output logic        busy,
    input  logic [15:0] SRAM_read_data,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n
);
    localparam int unsigned KW = (GROUP > 1) ? $clog2(GROUP) : 1;
    localparam int unsigned BW = $clog2(NUM_BLOCKS + 1);
    localparam logic [KW-1:0] KLast  = KW'(GROUP - 1);
    localparam logic [KW-1:0] KOne   = KW'(1);
    localparam logic [BW-1:0] BlkEnd = BW'(NUM_BLOCKS);
    localparam logic [BW-1:0] BlkOne = BW'(1);
    localparam logic [6:0]    Grp7   = 7'(GROUP);

    // Zig-zag index to raster index
    localparam logic [5:0] ZZ2R [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    typedef enum logic [2:0] {StIdle, StRead, StDrain, StWrite, StDone} state_e;

    state_e        state_q;
    logic          qsel_q;
    logic          drain_q;
    logic [BW-1:0] blk_q;
    logic [6:0]    zz_q;
    logic [KW-1:0] k_q;

    logic          vld1_q, vld2_q;
    logic [KW-1:0] idx1_q, idx2_q;
    logic [15:0]   buf_q [2**KW];

    logic [6:0]    grp_end, nxt_zz;
    logic [BW-1:0] nxt_blk;
    logic [5:0]    rd_off, wr_zz, wr_raster;
    logic [KW-1:0] wr_k;
    logic [15:0]   wr_src;

    function automatic logic [2:0] shift_amt(input logic [5:0] r, input logic q);
        logic [3:0] d;
        d = 4'(r[5:3]) + 4'(r[2:0]);
        if (!q) begin
            if (d == 4'd0)      return 3'd3;
            else if (d == 4'd1) return 3'd2;
            else if (d <= 4'd3) return 3'd3;
            else if (d <= 4'd5) return 3'd4;
            else if (d <= 4'd7) return 3'd5;
            else                return 3'd6;
        end else begin
            if (d == 4'd0)      return 3'd3;
            else if (d <= 4'd3) return 3'd1;
            else if (d <= 4'd5) return 3'd2;
            else if (d <= 4'd7) return 3'd3;
            else if (d <= 4'd9) return 3'd4;
            else                return 3'd5;
        end
    endfunction

    function automatic logic [15:0] deq(input logic [15:0] c, input logic [2:0] s);
        logic signed [22:0] wide;
        wide = {{7{c[15]}}, c};
        wide = wide <<< s;
`ifdef M3_SATURATE_EN
        if (wide > 23'sd32767)       return 16'h7FFF;
        else if (wide < -23'sd32768) return 16'h8000;
        else                         return wide[15:0];
`else
        return wide[15:0];
`endif
    endfunction

    // Address sums wrap modulo 2^18
    function automatic logic [17:0] blk_addr(input logic [17:0] base, input logic [BW-1:0] blk,
                                             input logic [5:0] off);
        logic [17:0] b18;
        b18 = 18'(blk);
        return base + {b18[11:0], 6'b0} + {12'b0, off};
    endfunction

    // Next read offset, next-group position, and the operands of the next write beat
    always_comb begin
        grp_end   = zz_q + Grp7;
        nxt_zz    = (grp_end == 7'd64) ? 7'd0 : grp_end;
        nxt_blk   = (grp_end == 7'd64) ? blk_q + BlkOne : blk_q;
        rd_off    = 6'(zz_q + 7'(k_q) + 7'd1);
        wr_k      = (state_q == StWrite) ? k_q + KOne : '0;
        wr_zz     = 6'(zz_q + 7'(wr_k));
        wr_raster = ZZ2R[wr_zz];
        // With GROUP=1 the word lands on the same edge its write beat is loaded
        wr_src    = (vld2_q && idx2_q == wr_k) ? SRAM_read_data : buf_q[wr_k];
    end

    // Track the buffer slot of each in-flight read and capture it two cycles later
    always_ff @(posedge Clock_50) begin
        if (!Resetn) begin
            vld1_q <= 1'b0;
            vld2_q <= 1'b0;
            idx1_q <= '0;
            idx2_q <= '0;
        end else begin
            vld1_q <= (state_q == StRead);
            idx1_q <= k_q;
            vld2_q <= vld1_q;
            idx2_q <= idx1_q;
            if (vld2_q) buf_q[idx2_q] <= SRAM_read_data;
        end
    end

    // Sequencer FSM with registered SRAM and handshake outputs
    always_ff @(posedge Clock_50) begin
        if (!Resetn) begin
            state_q         <= StIdle;
            milestone_done  <= 1'b0;
            busy            <= 1'b0;
            SRAM_address    <= '0;
            SRAM_write_data <= '0;
            SRAM_we_n       <= 1'b1;
            qsel_q          <= 1'b0;
            drain_q         <= 1'b0;
            blk_q           <= '0;
            zz_q            <= '0;
            k_q             <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (milestone_start && !milestone_done) begin
                        qsel_q       <= q_sel;
                        blk_q        <= '0;
                        zz_q         <= '0;
                        k_q          <= '0;
                        SRAM_address <= SRC_BASE;
                        busy         <= 1'b1;
                        state_q      <= StRead;
                    end else if (milestone_done && !milestone_start) begin
                        milestone_done <= 1'b0;
                    end
                end
                StRead: begin
                    if (k_q == KLast) begin
                        k_q     <= '0;
                        drain_q <= 1'b0;
                        state_q <= StDrain;
                    end else begin
                        k_q          <= k_q + KOne;
                        SRAM_address <= blk_addr(SRC_BASE, blk_q, rd_off);
                    end
                end
                StDrain: begin
                    drain_q <= 1'b1;
                    if (drain_q) begin
                        SRAM_address    <= blk_addr(DST_BASE, blk_q, wr_raster);
                        SRAM_write_data <= deq(wr_src, shift_amt(wr_raster, qsel_q));
                        SRAM_we_n       <= 1'b0;
                        state_q         <= StWrite;
                    end
                end
                StWrite: begin
                    if (k_q == KLast) begin
                        SRAM_we_n <= 1'b1;
                        k_q       <= '0;
                        zz_q      <= nxt_zz;
                        blk_q     <= nxt_blk;
                        if (nxt_blk == BlkEnd) begin
                            state_q <= StDone;
                        end else begin
                            SRAM_address <= blk_addr(SRC_BASE, nxt_blk, 6'(nxt_zz));
                            state_q      <= StRead;
                        end
                    end else begin
                        k_q             <= k_q + KOne;
                        SRAM_address    <= blk_addr(DST_BASE, blk_q, wr_raster);
                        SRAM_write_data <= deq(wr_src, shift_amt(wr_raster, qsel_q));
                    end
                end
                StDone: begin
                    SRAM_we_n      <= 1'b1;
                    milestone_done <= 1'b1;
                    busy           <= 1'b0;
                    state_q        <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_m3_dequant_engine.sv
// Bench for m3_dequant_engine: four instances (GROUP 8/1/4/16) share the control inputs,
// each with its own SRAM model and a queue of expected writes in zig-zag order.
module tb_m3_dequant_engine;
    localparam int NI = 4;
    localparam int GS [NI] = '{8, 1, 4, 16};
    localparam int NB [NI] = '{1, 3, 3, 3};
    localparam logic [17:0] SRC = 18'd76800;
    localparam logic [17:0] DB [NI] = '{18'd153600, 18'd153600, 18'd153600, 18'd262100};

    typedef struct {
        logic [17:0] a;
        logic [15:0] d;
    } wr_t;

    typedef struct {
        logic        q;
        int          zz;
        logic [15:0] src;
        int          off;
        logic [15:0] exp;
    } vec_t;

    logic Clock_50 = 1'b0;
    logic Resetn = 1'b0;
    logic milestone_start = 1'b0;
    logic q_sel = 1'b0;

    logic        done [NI];
    logic        busy [NI];
    logic        we_n [NI];
    logic [17:0] addr [NI];
    logic [15:0] wdata [NI];
    logic [15:0] rp1 [NI];
    logic [15:0] rp2 [NI];

    logic [15:0] mem [NI][262144];
    wr_t         exp_q [NI][$];
    int          busy_cnt [NI];
    int          wr_cnt [NI];
    int          n_chk = 0;
    int          n_fail = 0;
    int          zz2r [64];
    vec_t        tv [10];

    always #10 Clock_50 = ~Clock_50;

    for (genvar i = 0; i < NI; i++) begin : g_dut
        m3_dequant_engine #(
            .NUM_BLOCKS(NB[i]),
            .SRC_BASE  (SRC),
            .DST_BASE  (DB[i]),
            .GROUP     (GS[i])
        ) u_dut (
            .Clock_50       (Clock_50),
            .Resetn         (Resetn),
            .milestone_start(milestone_start),
            .q_sel          (q_sel),
            .milestone_done (done[i]),
            .busy           (busy[i]),
            .SRAM_read_data (rp2[i]),
            .SRAM_address   (addr[i]),
            .SRAM_write_data(wdata[i]),
            .SRAM_we_n      (we_n[i])
        );
    end

    // SRAM read path: data appears two cycles after its address
    always @(posedge Clock_50) begin
        for (int i = 0; i < NI; i++) begin
            rp1[i] <= mem[i][addr[i]];
            rp2[i] <= rp1[i];
        end
    end

    task automatic chk(input string nm, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d got=%h want=%h", nm, inst, act, exp);
        end
    endtask

    function automatic logic [15:0] tb_deq(input logic [15:0] c, input int r, input logic q);
        int d, s, cv, v;
        d = r / 8 + r % 8;
        if (!q) s = (d == 0) ? 3 : (d == 1) ? 2 : (d <= 3) ? 3 : (d <= 5) ? 4 : (d <= 7) ? 5 : 6;
        else    s = (d == 0) ? 3 : (d <= 3) ? 1 : (d <= 5) ? 2 : (d <= 7) ? 3 : (d <= 9) ? 4 : 5;
        cv = int'($signed(c));
        v = cv * (1 << s);
`ifdef M3_SATURATE_EN
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
`endif
        return 16'(v);
    endfunction

    // One cycle: sample at negedge, apply SRAM writes and score them
    task automatic tick();
        wr_t e;
        @(negedge Clock_50);
        for (int i = 0; i < NI; i++) begin
            if (busy[i]) busy_cnt[i]++;
            if (!we_n[i]) begin
                wr_cnt[i]++;
                mem[i][addr[i]] = wdata[i];
                if (exp_q[i].size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write inst=%0d got addr=%h data=%h want none",
                             i, addr[i], wdata[i]);
                end else begin
                    e = exp_q[i].pop_front();
                    chk("wr_addr", i, 32'(addr[i]), 32'(e.a));
                    chk("wr_data", i, 32'(wdata[i]), 32'(e.d));
                end
            end
        end
    endtask

    task automatic chk_reset();
        for (int i = 0; i < NI; i++) begin
            chk("rst_done", i, 32'(done[i]), 0);
            chk("rst_busy", i, 32'(busy[i]), 0);
            chk("rst_addr", i, 32'(addr[i]), 0);
            chk("rst_wdata", i, 32'(wdata[i]), 0);
            chk("rst_we_n", i, 32'(we_n[i]), 1);
        end
    endtask

    // Load sources, poison destinations, queue the expected writes
    task automatic prep(input logic q);
        wr_t e;
        int  r;
        for (int i = 0; i < NI; i++) begin
            exp_q[i].delete();
            busy_cnt[i] = 0;
            wr_cnt[i] = 0;
            for (int b = 0; b < NB[i]; b++)
                for (int z = 0; z < 64; z++) begin
                    mem[i][18'(int'(SRC) + b * 64 + z)] = (i == 0) ? 16'h0 : 16'(z);
                    mem[i][18'(int'(DB[i]) + b * 64 + z)] = 16'hDEAD;
                end
        end
        for (int t = 0; t < 10; t++)
            if (tv[t].q == q) mem[0][18'(int'(SRC) + tv[t].zz)] = tv[t].src;
        for (int i = 0; i < NI; i++)
            for (int b = 0; b < NB[i]; b++)
                for (int z = 0; z < 64; z++) begin
                    r = zz2r[z];
                    e.a = 18'(int'(DB[i]) + b * 64 + r);
                    e.d = tb_deq(mem[i][18'(int'(SRC) + b * 64 + z)], r, q);
                    exp_q[i].push_back(e);
                end
    endtask

    task automatic run(input logic q, input logic flip);
        int cyc;
        bit all;
        prep(q);
        tick();
        q_sel = q;
        milestone_start = 1'b1;
        cyc = 0;
        all = 1'b0;
        while (!all && cyc < 5000) begin
            tick();
            cyc++;
            if (flip && cyc == 10) q_sel = ~q;
            all = done[0] && done[1] && done[2] && done[3];
        end
        chk("run_completes", 0, 32'(all), 1);
        for (int i = 0; i < NI; i++) begin
            chk("busy_cycles", i, busy_cnt[i], NB[i] * (64 / GS[i]) * (2 * GS[i] + 2) + 1);
            chk("write_cycles", i, wr_cnt[i], NB[i] * 64);
            chk("scoreboard_drained", i, exp_q[i].size(), 0);
        end
        for (int t = 0; t < 10; t++)
            if (tv[t].q == q)
                chk("dst_word", tv[t].off, 32'(mem[0][18'(int'(DB[0]) + tv[t].off)]),
                    32'(tv[t].exp));
    endtask

    initial begin
        int n, cyc;
        n = 0;
        // Walk anti-diagonals: odd sums go down the rows, even sums go up
        for (int d = 0; d < 15; d++) begin
            int lo, hi;
            lo = (d > 7) ? d - 7 : 0;
            hi = (d < 7) ? d : 7;
            if (d % 2 == 1) begin
                for (int r = lo; r <= hi; r++) begin zz2r[n] = r * 8 + d - r; n++; end
            end else begin
                for (int r = hi; r >= lo; r--) begin zz2r[n] = r * 8 + d - r; n++; end
            end
        end

        tv[0] = '{1'b0, 0,  16'd5,    0,  16'd40};
        tv[1] = '{1'b0, 1,  16'hFFFD, 1,  16'hFFF4};
        tv[2] = '{1'b0, 2,  16'd7,    8,  16'd28};
        tv[3] = '{1'b0, 5,  16'd3,    2,  16'd24};
`ifdef M3_SATURATE_EN
        tv[4] = '{1'b0, 63, 16'd1000, 63, 16'h7FFF};
        tv[5] = '{1'b0, 62, 16'hFC18, 62, 16'h8000};
`else
        tv[4] = '{1'b0, 63, 16'd1000, 63, 16'hFA00};
        tv[5] = '{1'b0, 62, 16'hFC18, 62, 16'h0600};
`endif
        tv[6] = '{1'b1, 0,  16'd5,    0,  16'd40};
        tv[7] = '{1'b1, 1,  16'hFFFD, 1,  16'hFFFA};
        tv[8] = '{1'b1, 2,  16'd7,    8,  16'd14};
        tv[9] = '{1'b1, 63, 16'd1000, 63, 16'h7D00};

        Resetn = 1'b0;
        repeat (3) tick();
        chk_reset();
        Resetn = 1'b1;
        tick();

        run(1'b0, 1'b0);

        // Start held high after done: no restart
        repeat (20) tick();
        for (int i = 0; i < NI; i++) begin
            chk("hold_busy", i, 32'(busy[i]), 0);
            chk("hold_done", i, 32'(done[i]), 1);
            chk("hold_no_writes", i, wr_cnt[i], NB[i] * 64);
        end
        milestone_start = 1'b0;
        tick();
        for (int i = 0; i < NI; i++) chk("done_falls", i, 32'(done[i]), 0);

        // Second run with q_sel toggled mid-run must repeat the first
        run(1'b0, 1'b1);
        milestone_start = 1'b0;
        repeat (2) tick();

        run(1'b1, 1'b0);
        milestone_start = 1'b0;
        repeat (2) tick();

        // Reset during a write beat
        prep(1'b0);
        q_sel = 1'b0;
        milestone_start = 1'b1;
        cyc = 0;
        while (we_n[0] && cyc < 500) begin
            tick();
            cyc++;
        end
        chk("reached_write", 0, 32'(we_n[0]), 0);
        Resetn = 1'b0;
        milestone_start = 1'b0;
        tick();
        chk_reset();
        repeat (3) begin
            tick();
            for (int i = 0; i < NI; i++) chk("rst_we_n_held", i, 32'(we_n[i]), 1);
        end
        for (int i = 0; i < NI; i++) exp_q[i].delete();
        Resetn = 1'b1;
        tick();

        run(1'b0, 1'b0);
        milestone_start = 1'b0;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
